acc_host_ctrl: RTL and testbench

ACC_HOST_CTRL -- requirements
Module: acc_host_ctrl

---
 rtl/acc_host_ctrl_if.sv | 24 ++
 rtl/acc_host_ctrl.sv | 113 +++++++++++
 tb/tb_acc_host_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/acc_host_ctrl_if.sv
// acc_host_ctrl_if: accelerator-side trigger, result handshake and weight-serving signals
interface acc_host_ctrl_if #(
    parameter int NUM_ROW      = 46,
    parameter int WORD_WIDTH   = 4,
    parameter int ENERGY_WIDTH = 16
);
    logic                          sample;
    logic                          done;
    logic                          done_ack;
    logic                          address_enable;
    logic [$clog2(NUM_ROW-1)-1:0]  row_number;
    logic [WORD_WIDTH*NUM_ROW-1:0] row_weight;
    logic [WORD_WIDTH*NUM_ROW-1:0] col_weight;
    logic [NUM_ROW-1:0]            best_spin;
    logic [ENERGY_WIDTH:0]         best_hamiltonian;
    modport master (
        output sample, done_ack, row_weight, col_weight,
        input  done, address_enable, row_number, best_spin, best_hamiltonian
    );
    modport slave (
        input  sample, done_ack, row_weight, col_weight,
        output done, address_enable, row_number, best_spin, best_hamiltonian
    );
endinterface

// File: rtl/acc_host_ctrl.sv
// acc_host_ctrl: host weight banks, run sequencing and best-energy capture for an Ising accelerator
module acc_host_ctrl #(
    parameter int NUM_ROW      = 46,
    parameter int WORD_WIDTH   = 4,
    parameter int ENERGY_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic                          wr_bank,
    input  logic [$clog2(NUM_ROW)-1:0]    wr_row,
    input  logic [WORD_WIDTH*NUM_ROW-1:0] wr_data,
    input  logic                          start,
    input  logic [7:0]                    num_runs,
    input  logic [15:0]                   timeout,
    acc_host_ctrl_if.master               acc,
    output logic [NUM_ROW-1:0]            res_spin,
    output logic [ENERGY_WIDTH:0]         res_energy,
    output logic                          res_valid,
    output logic                          busy,
    output logic                          wr_err,
    output logic                          timeout_err
);
    typedef enum logic [1:0] {IDLE, TRIG, WAIT, ACK} state_t;
    state_t state, state_nx;
    logic [WORD_WIDTH*NUM_ROW-1:0] bank_row [NUM_ROW];
    logic [WORD_WIDTH*NUM_ROW-1:0] bank_col [NUM_ROW];
    logic [7:0]  run_cnt;
    logic [1:0]  trig_cnt;
    logic [15:0] tmo_cnt;
    logic        have;
    logic        go, cap, tmo_hit, wr_ok, rd_ok, last_run;
    assign go       = state == IDLE && start;
    assign cap      = state == WAIT && acc.done;
    assign tmo_hit  = state == WAIT && !acc.done && ({1'b0, tmo_cnt} + 17'd1 >= {1'b0, timeout});
    assign wr_ok    = state == IDLE && 32'(wr_row) < NUM_ROW;
    assign rd_ok    = 32'(acc.row_number) < NUM_ROW;
    assign last_run = run_cnt <= 8'd1;
    assign acc.sample   = state == TRIG;
    assign acc.done_ack = state == ACK;
    assign busy         = state != IDLE;
    // state register
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;
    // next-state: four trigger cycles, wait for done or timeout, hold ack until done falls
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? TRIG : IDLE;
            TRIG:    state_nx = trig_cnt == 2'd3 ? WAIT : TRIG;
            WAIT:    state_nx = acc.done ? ACK : tmo_hit ? IDLE : WAIT;
            ACK:     state_nx = acc.done ? ACK : last_run ? IDLE : TRIG;
            default: state_nx = IDLE;
        endcase
    end
    // trigger, timeout and run counters; timeout count restarts on every WAIT entry
    always_ff @(posedge clk)
        if (reset) begin
            run_cnt  <= '0;
            trig_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            trig_cnt <= state == TRIG ? trig_cnt + 2'd1 : 2'd0;
            tmo_cnt  <= state == WAIT ? tmo_cnt + 16'd1 : 16'd0;
            if (go)
                run_cnt <= num_runs == 8'd0 ? 8'd1 : num_runs;
            else if (state == ACK && !acc.done)
                run_cnt <= run_cnt - 8'd1;
        end
    // keep the lowest signed energy seen since the last accepted start
    always_ff @(posedge clk)
        if (reset) begin
            res_spin   <= '0;
            res_energy <= '0;
            res_valid  <= 1'b0;
            have       <= 1'b0;
        end else begin
            res_valid <= cap;
            if (go)
                have <= 1'b0;
            else if (cap && (!have || $signed(acc.best_hamiltonian) < $signed(res_energy))) begin
                res_spin   <= acc.best_spin;
                res_energy <= acc.best_hamiltonian;
                have       <= 1'b1;
            end
        end
    // sticky error flags, cleared by an accepted start; a rejected write in that same cycle still sets wr_err
    always_ff @(posedge clk)
        if (reset) begin
            wr_err      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            wr_err      <= (wr_en && !wr_ok) || (wr_err && !go);
            timeout_err <= tmo_hit || (timeout_err && !go);
        end
    // weight banks survive reset
    always_ff @(posedge clk)
        if (wr_en && wr_ok) begin
            if (wr_bank)
                bank_col[wr_row] <= wr_data;
            else
                bank_row[wr_row] <= wr_data;
        end
    // serve the addressed row one cycle after a fetch, holding between fetches
    always_ff @(posedge clk)
        if (reset) begin
            acc.row_weight <= '0;
            acc.col_weight <= '0;
        end else if (acc.address_enable) begin
            acc.row_weight <= rd_ok ? bank_row[acc.row_number] : '0;
            acc.col_weight <= rd_ok ? bank_col[acc.row_number] : '0;
        end
endmodule

// File: tb/tb_acc_host_ctrl.sv
// tb_acc_host_ctrl: vector table for weight banks plus directed run sequences
module tb_acc_host_ctrl;
    localparam int NR = 46, WW = 4, EW = 16, DW = WW * NR;
    typedef struct {
        logic       bank;
        logic [5:0] row;
        logic [3:0] wnib;
        logic [5:0] rrow;
        logic [3:0] er;
        logic [3:0] ec;
        logic       eerr;
    } vec_t;
    logic clk = 0, reset = 1, wr_en = 0, wr_bank = 0, start = 0;
    logic [5:0] wr_row = '0;
    logic [DW-1:0] wr_data = '0;
    logic [7:0] num_runs = 8'd1;
    logic [15:0] timeout = 16'd1000;
    logic [NR-1:0] res_spin;
    logic [EW:0] res_energy;
    logic res_valid, busy, wr_err, timeout_err;
    int n_chk = 0, n_fail = 0;
    vec_t tab[6];
    acc_host_ctrl_if #(.NUM_ROW(NR), .WORD_WIDTH(WW), .ENERGY_WIDTH(EW)) bus();
    acc_host_ctrl #(.NUM_ROW(NR), .WORD_WIDTH(WW), .ENERGY_WIDTH(EW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_bank(wr_bank), .wr_row(wr_row),
        .wr_data(wr_data), .start(start), .num_runs(num_runs), .timeout(timeout),
        .acc(bus), .res_spin(res_spin), .res_energy(res_energy), .res_valid(res_valid),
        .busy(busy), .wr_err(wr_err), .timeout_err(timeout_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask
    function automatic logic [DW-1:0] rep(input logic [3:0] n);
        return {NR{n}};
    endfunction
    task automatic wr(input logic b, input logic [5:0] r, input logic [DW-1:0] d);
        wr_en = 1; wr_bank = b; wr_row = r; wr_data = d;
        step();
        wr_en = 0;
    endtask
    task automatic rd(input logic [5:0] r);
        bus.address_enable = 1; bus.row_number = r;
        step();
        bus.address_enable = 0;
    endtask
    task automatic pulse_start();
        start = 1;
        step();
        start = 0;
    endtask
    task automatic reset_checks(input string tag);
        chk({tag, "_sample"}, DW'(bus.sample), '0);
        chk({tag, "_done_ack"}, DW'(bus.done_ack), '0);
        chk({tag, "_busy"}, DW'(busy), '0);
        chk({tag, "_res_valid"}, DW'(res_valid), '0);
        chk({tag, "_wr_err"}, DW'(wr_err), '0);
        chk({tag, "_timeout_err"}, DW'(timeout_err), '0);
        chk({tag, "_res_spin"}, DW'(res_spin), '0);
        chk({tag, "_res_energy"}, DW'(res_energy), '0);
        chk({tag, "_row_weight"}, bus.row_weight, '0);
        chk({tag, "_col_weight"}, bus.col_weight, '0);
    endtask
    task automatic run_acc(input logic [EW:0] e, input logic [NR-1:0] s, input int dly);
        int c = 0;
        while (!bus.sample && c < 20) begin step(); c++; end
        chk("sample_seen", DW'(bus.sample), DW'(1));
        c = 0;
        while (bus.sample && c < 10) begin step(); c++; end
        chk("sample_len", DW'(c), DW'(4));
        step(dly);
        chk("no_ack_in_wait", DW'(bus.done_ack), '0);
        bus.done = 1; bus.best_spin = s; bus.best_hamiltonian = e;
        step();
        chk("res_valid_hi", DW'(res_valid), DW'(1));
        chk("ack_hi", DW'(bus.done_ack), DW'(1));
        step();
        chk("res_valid_pulse", DW'(res_valid), '0);
        chk("ack_hold", DW'(bus.done_ack), DW'(1));
        bus.done = 0;
        step();
        chk("ack_drop", DW'(bus.done_ack), '0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [EW:0] e_tab[3];
        logic [NR-1:0] s_tab[3];
        logic [EW:0] e_exp[3];
        logic seen_ack;
        e_tab = '{17'h1FFFB, 17'h1FFF7, 17'h1FFFE};
        e_exp = '{17'h1FFFB, 17'h1FFF7, 17'h1FFF7};
        s_tab = '{46'h111, 46'h2222, 46'h33333};
        tab[0] = '{1'b0, 6'd3,  4'hA, 6'd3,  4'hA, 4'h0, 1'b0};
        tab[1] = '{1'b1, 6'd3,  4'h5, 6'd3,  4'hA, 4'h5, 1'b0};
        tab[2] = '{1'b0, 6'd45, 4'hF, 6'd45, 4'hF, 4'h0, 1'b0};
        tab[3] = '{1'b1, 6'd0,  4'hC, 6'd0,  4'h0, 4'hC, 1'b0};
        tab[4] = '{1'b0, 6'd46, 4'h7, 6'd45, 4'hF, 4'h0, 1'b1};
        tab[5] = '{1'b0, 6'd0,  4'h1, 6'd50, 4'h0, 4'h0, 1'b1};
        bus.done = 0; bus.address_enable = 0; bus.row_number = '0;
        bus.best_spin = '0; bus.best_hamiltonian = '0;
        step(2);
        reset_checks("rst");
        reset = 0;
        for (int i = 0; i < NR; i++) begin
            wr(1'b0, 6'(i), '0);
            wr(1'b1, 6'(i), '0);
        end
        for (int i = 0; i < 6; i++) begin
            wr(tab[i].bank, tab[i].row, rep(tab[i].wnib));
            rd(tab[i].rrow);
            chk($sformatf("vec%0d_row", i), bus.row_weight, rep(tab[i].er));
            chk($sformatf("vec%0d_col", i), bus.col_weight, rep(tab[i].ec));
            chk($sformatf("vec%0d_wr_err", i), DW'(wr_err), DW'(tab[i].eerr));
        end
        rd(6'd3);
        bus.row_number = 6'd45;
        step();
        chk("weight_hold", bus.row_weight, rep(4'hA));
        num_runs = 8'd1;
        pulse_start();
        chk("single_busy", DW'(busy), DW'(1));
        chk("start_clears_wr_err", DW'(wr_err), '0);
        run_acc(17'h00007, 46'h123, 10);
        chk("single_idle", DW'(busy), '0);
        chk("single_energy", DW'(res_energy), DW'(17'h00007));
        chk("single_spin", DW'(res_spin), DW'(46'h123));
        num_runs = 8'd3;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            run_acc(e_tab[k], s_tab[k], 3);
            chk($sformatf("multi%0d_energy", k), DW'(res_energy), DW'(e_exp[k]));
            chk($sformatf("multi%0d_busy", k), DW'(busy), DW'(k < 2));
        end
        chk("multi_spin", DW'(res_spin), DW'(s_tab[1]));
        num_runs = 8'd1;
        pulse_start();
        bus.done = 1; bus.best_hamiltonian = 17'd100; bus.best_spin = 46'h3F;
        step(5);
        chk("early_done_valid", DW'(res_valid), DW'(1));
        chk("early_done_ack", DW'(bus.done_ack), DW'(1));
        chk("early_done_first_load", DW'(res_energy), DW'(17'd100));
        bus.done = 0;
        step();
        chk("early_done_idle", DW'(busy), '0);
        num_runs = 8'd0;
        start = 1;
        run_acc(17'h00020, 46'h5, 2);
        chk("zero_runs_idle", DW'(busy), '0);
        step();
        chk("restart_busy", DW'(busy), DW'(1));
        chk("restart_sample", DW'(bus.sample), DW'(1));
        start = 0;
        run_acc(17'h00030, 46'h6, 2);
        chk("restart_done", DW'(busy), '0);
        timeout = 16'd20;
        num_runs = 8'd1;
        pulse_start();
        step(4);
        seen_ack = 0;
        for (int i = 0; i < 19; i++) begin
            step();
            seen_ack |= bus.done_ack;
        end
        chk("tmo_not_yet", DW'(timeout_err), '0);
        chk("tmo_busy", DW'(busy), DW'(1));
        step();
        seen_ack |= bus.done_ack;
        chk("tmo_err", DW'(timeout_err), DW'(1));
        chk("tmo_idle", DW'(busy), '0);
        chk("tmo_no_ack", DW'(seen_ack), '0);
        timeout = 16'd1000;
        wr(1'b0, 6'd60, rep(4'h2));
        chk("bad_row_err", DW'(wr_err), DW'(1));
        pulse_start();
        chk("start_clears_both", DW'({wr_err, timeout_err}), '0);
        step(4);
        wr(1'b0, 6'd3, rep(4'h1));
        chk("wait_wr_err", DW'(wr_err), DW'(1));
        bus.done = 1; bus.best_hamiltonian = 17'd9; bus.best_spin = 46'h9;
        step();
        chk("mid_ack", DW'(bus.done_ack), DW'(1));
        reset = 1;
        step();
        reset_checks("midrst");
        reset = 0; bus.done = 0;
        rd(6'd3);
        chk("keep_row3", bus.row_weight, rep(4'hA));
        chk("keep_col3", bus.col_weight, rep(4'h5));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
